// File: rtl/mult_arbiter_ctrl.sv
// rtl/mult_arbiter_ctrl.sv - two-requester round-robin front end for an external pipelined multiplier
module mult_arbiter_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int MULT_LAT   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*DATA_WIDTH-1:0] req_a,
  input  logic [2*DATA_WIDTH-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic [2*DATA_WIDTH-1:0] rsp_data,
  output logic                    EA,
  output logic                    EB,
  output logic [DATA_WIDTH-1:0]   A_in,
  output logic [DATA_WIDTH-1:0]   B_in,
  input  logic [2*DATA_WIDTH-1:0] P_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MULT_LAT);

  state_t                  state_q, state_d;
  logic                    ptr_q, ptr_d;
  logic                    id_q, id_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [2*DATA_WIDTH-1:0] data_q, data_d;
  logic                    en_q, en_d;
  logic                    valid_q, valid_d;
  logic [1:0]              grant;
  logic                    win_id;

  // Pointer names the requester preferred on a tie; the grant is gated by
  // rst_n so req_ready drops the instant reset asserts.
  always_comb begin
    win_id = 1'b0;
    case (req_valid)
      2'b01:   win_id = 1'b0;
      2'b10:   win_id = 1'b1;
      2'b11:   win_id = ptr_q;
      default: win_id = 1'b0;
    endcase
    grant = 2'b00;
    if (rst_n && (state_q == IDLE) && (req_valid != 2'b00)) begin
      grant[win_id] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    en_d    = 1'b0;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          state_d = ISSUE;
          id_d    = win_id;
          ptr_d   = ~win_id;
          a_d     = win_id ? req_a[2*DATA_WIDTH-1:DATA_WIDTH] : req_a[DATA_WIDTH-1:0];
          b_d     = win_id ? req_b[2*DATA_WIDTH-1:DATA_WIDTH] : req_b[DATA_WIDTH-1:0];
          en_d    = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = LAT_LOAD;
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          data_d  = P_out;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      en_q    <= en_d;
      valid_q <= valid_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign EA        = en_q;
  assign EB        = en_q;
  assign A_in      = a_q;
  assign B_in      = b_q;

endmodule

// File: tb/tb_mult_arbiter_ctrl.sv
// tb/tb_mult_arbiter_ctrl.sv - directed and random checks of mult_arbiter_ctrl with a scoreboard
module tb_mult_arbiter_ctrl;
  localparam int DW  = 4;
  localparam int LAT = 2;

  typedef struct {
    logic id;
    int   prod;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [2*DW-1:0] req_a = '0;
  logic [2*DW-1:0] req_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_id;
  logic [2*DW-1:0] rsp_data;
  logic          EA, EB;
  logic [DW-1:0] A_in, B_in;
  logic [2*DW-1:0] P_out = '0;
  logic [DW-1:0] ma = '0;
  logic [DW-1:0] mb = '0;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic grant_log[$];
  bit   busy = 0;
  int   since = 0;
  bit   ptr = 0;
  bit   auto_drop = 1;
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;

  always #5 clk = ~clk;

  mult_arbiter_ctrl #(.DATA_WIDTH(DW), .MULT_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .EA(EA), .EB(EB),
    .A_in(A_in), .B_in(B_in), .P_out(P_out)
  );

  // Multiplier: operand registers loaded on EA/EB, one product register.
  always @(posedge clk) begin
    if (EA) ma <= A_in;
    if (EB) mb <= B_in;
    P_out <= (2*DW)'(ma) * (2*DW)'(mb);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: check at the falling edge, update the model, then return 1ns
  // after the rising edge so the caller can drive the next inputs.
  task automatic cyc();
    logic [1:0]    exp_rdy;
    logic [1:0]    drop;
    logic          exp_en, exp_val, id;
    logic [DW-1:0] a, b;
    drop = 2'b00;
    @(negedge clk);
    if (busy) since++;
    exp_rdy = 2'b00;
    if (rst_n && !busy && req_valid != 2'b00)
      exp_rdy = (req_valid == 2'b11) ? (ptr ? 2'b10 : 2'b01) : req_valid;
    exp_en  = rst_n && busy && (since == 1);
    // Accept edge counts as the first of the LAT+2 edges before rsp_valid.
    exp_val = rst_n && busy && (since >= LAT + 2);
    chk("req_ready", req_ready, exp_rdy);
    chk("ready_onehot0", $onehot0(req_ready), 1);
    chk("ea", EA, exp_en);
    chk("eb", EB, exp_en);
    chk("a_in", A_in, last_a);
    chk("b_in", B_in, last_b);
    chk("rsp_valid", rsp_valid, exp_val);
    if (req_ready != 2'b00) grant_log.push_back(req_ready[1]);
    if (exp_val && sb.size() > 0) begin
      chk("rsp_id", rsp_id, sb[0].id);
      chk("rsp_data", rsp_data, sb[0].prod);
      if (rsp_ready) begin
        void'(sb.pop_front());
        busy = 0;
      end
    end
    if (exp_rdy != 2'b00) begin
      id = exp_rdy[1];
      a  = id ? req_a[2*DW-1:DW] : req_a[DW-1:0];
      b  = id ? req_b[2*DW-1:DW] : req_b[DW-1:0];
      sb.push_back('{id, int'(a) * int'(b)});
      ptr    = ~id;
      busy   = 1;
      since  = 0;
      last_a = a;
      last_b = b;
      if (auto_drop) drop[id] = 1'b1;
    end
    @(posedge clk);
    #1;
    req_valid = req_valid & ~drop;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_ea", EA, 0);
    chk("rst_eb", EB, 0);
    chk("rst_a_in", A_in, 0);
    chk("rst_b_in", B_in, 0);
    sb.delete();
    busy = 0; since = 0; ptr = 0; last_a = '0; last_b = '0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((busy || req_valid != 2'b00) && n < bound) begin
      cyc();
      n++;
    end
    chk("drain_done", (busy || req_valid != 2'b00), 0);
  endtask

  initial begin
    logic exp_seq[4];
    int   n;
    logic id;
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Reset with both requests pending: req_ready must stay low.
    #2;
    req_valid = 2'b11;
    req_a = {4'd15, 4'd7};
    req_b = {4'd15, 4'd5};
    do_reset();

    // Both requesters held valid: grants alternate starting with 0.
    auto_drop = 0;
    grant_log.delete();
    n = 0;
    while (grant_log.size() < 4 && n < 60) begin
      cyc();
      n++;
    end
    req_valid = 2'b00;
    drain(40);
    chk("rr_grants", grant_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size()) chk("rr_order", grant_log[i], exp_seq[i]);
    auto_drop = 1;

    // Requester 0 alone, 3x2.
    req_a = {4'd0, 4'd3};
    req_b = {4'd0, 4'd2};
    req_valid = 2'b01;
    drain(40);

    // Requester 1 alone, 15x1, response stalled; requester 0 waits meanwhile.
    rsp_ready = 1'b0;
    req_a = {4'd15, 4'd9};
    req_b = {4'd1, 4'd9};
    req_valid = 2'b10;
    repeat (LAT + 3) cyc();
    req_valid = 2'b01;
    repeat (5) cyc();
    rsp_ready = 1'b1;
    drain(40);

    // Reset while the multiplier is in flight, then a normal request.
    req_a = {4'd5, 4'd0};
    req_b = {4'd6, 4'd0};
    req_valid = 2'b10;
    repeat (3) cyc();
    do_reset();
    repeat (8) cyc();
    req_a = {4'd11, 4'd0};
    req_b = {4'd13, 4'd0};
    req_valid = 2'b10;
    drain(40);

    // Boundary operands.
    req_a = {4'd0, 4'd0};
    req_b = {4'd0, 4'd0};
    req_valid = 2'b01;
    drain(40);
    req_a = {4'd15, 4'd0};
    req_b = {4'd15, 4'd0};
    req_valid = 2'b10;
    drain(40);

    // Random pairs on a random requester, other lane filled with noise.
    for (int i = 0; i < 20; i++) begin
      id = 1'($urandom_range(0, 1));
      req_a = 8'($urandom_range(0, 255));
      req_b = 8'($urandom_range(0, 255));
      req_valid = id ? 2'b10 : 2'b01;
      drain(40);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
